// File: rtl/ca_cmp_seq_pkg.sv
// Shared types and constants for the CA/CS/CID/BCW/DCA packet comparator.
package ca_cmp_seq_pkg;

  localparam int unsigned CA_W       = 10;
  localparam int unsigned CS_W       = 1;
  localparam int unsigned CID_W      = 3;
  localparam int unsigned BCW_W      = 6;
  localparam int unsigned DCA_W      = 8;
  localparam int unsigned PKT_W      = CA_W + CS_W + CID_W + BCW_W + DCA_W;
  localparam int unsigned NUM_FIELDS = 5;
  localparam int unsigned MATCH_W    = 3;
  localparam int unsigned SEQ_W      = 8;
  localparam int unsigned TOT_W      = 16;

  // Field positions within the mismatch mask
  localparam int unsigned F_CA  = 0;
  localparam int unsigned F_CS  = 1;
  localparam int unsigned F_CID = 2;
  localparam int unsigned F_BCW = 3;
  localparam int unsigned F_DCA = 4;

  typedef struct packed {
    logic [CA_W-1:0]  ca;
    logic [CS_W-1:0]  cs_n;
    logic [CID_W-1:0] cid;
    logic [BCW_W-1:0] bcw;
    logic [DCA_W-1:0] dca;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACT = 2'd1,
    COMPARE  = 2'd2,
    REPORT   = 2'd3
  } state_t;

  // Per-field mismatch; case inequality so X/Z never counts as a match
  function automatic logic [NUM_FIELDS-1:0] field_mismatch(input pkt_t e, input pkt_t a);
    logic [NUM_FIELDS-1:0] m;
    m        = '0;
    m[F_CA]  = (e.ca   !== a.ca);
    m[F_CS]  = (e.cs_n !== a.cs_n);
    m[F_CID] = (e.cid  !== a.cid);
    m[F_BCW] = (e.bcw  !== a.bcw);
    m[F_DCA] = (e.dca  !== a.dca);
    return m;
  endfunction

endpackage

// File: rtl/ca_cmp_sequencer_if.sv
// Expected/actual/result handshakes of the comparator.
interface ca_cmp_sequencer_if;
  import ca_cmp_seq_pkg::*;

  logic                  exp_valid;
  logic                  exp_ready;
  pkt_t                  exp_pkt;
  logic                  act_valid;
  logic                  act_ready;
  pkt_t                  act_pkt;
  logic                  res_valid;
  logic                  res_ready;
  logic [NUM_FIELDS-1:0] res_mismatch;
  logic [MATCH_W-1:0]    res_match_cnt;
  logic                  res_timeout;
  logic [SEQ_W-1:0]      res_seq;

  modport master (
    output exp_valid, exp_pkt, act_valid, act_pkt, res_ready,
    input  exp_ready, act_ready, res_valid, res_mismatch, res_match_cnt,
           res_timeout, res_seq
  );

  modport slave (
    input  exp_valid, exp_pkt, act_valid, act_pkt, res_ready,
    output exp_ready, act_ready, res_valid, res_mismatch, res_match_cnt,
           res_timeout, res_seq
  );

endinterface

// File: rtl/ca_exp_fifo.sv
// Expected-packet FIFO; push and pop may coincide, pop on empty is ignored.
module ca_exp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < LW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/ca_cmp_sequencer.sv
// Compares queued expected packets against DUT packets field by field.
// Optional wait timeout enabled by defining CA_CMP_TIMEOUT_EN.
module ca_cmp_sequencer
  import ca_cmp_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  ca_cmp_sequencer_if.slave      bus,
  output logic [TOT_W-1:0]       pass_cnt,
  output logic [TOT_W-1:0]       fail_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT < 4 || TIMEOUT > 1023) begin : g_param_chk
    $error("ca_cmp_sequencer: DEPTH or TIMEOUT out of range");
  end

  state_t                state;
  state_t                state_next;
  pkt_t                  head;
  pkt_t                  exp_q;
  pkt_t                  act_q;
  logic [LW-1:0]         level;
  logic                  push;
  logic                  pop;
  logic                  act_hs;
  logic                  res_hs;
  logic                  tmo_hit;
  logic                  timed_out;
  logic                  act_ready_q;
  logic                  res_valid_q;
  logic                  busy_q;
  logic [NUM_FIELDS-1:0] mm_q;
  logic [MATCH_W-1:0]    mc_q;
  logic [SEQ_W-1:0]      seq_q;
  logic [TOT_W-1:0]      pass_q;
  logic [TOT_W-1:0]      fail_q;
  logic [NUM_FIELDS-1:0] mm_c;
  logic [MATCH_W-1:0]    mc_c;

  ca_exp_fifo #(.DEPTH(DEPTH), .WIDTH(PKT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.exp_pkt),
    .pop       (pop),
    .head      (head),
    .level     (level)
  );

  assign act_hs = (state == WAIT_ACT) && bus.act_valid;
  assign res_hs = (state == REPORT) && bus.res_ready;
  assign pop    = act_hs || tmo_hit;
  assign push   = bus.exp_valid && bus.exp_ready;

  assign bus.exp_ready     = !rst && ((level < LW'(DEPTH)) || pop);
  assign bus.act_ready     = act_ready_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_mismatch  = mm_q;
  assign bus.res_match_cnt = mc_q;
  assign bus.res_timeout   = timed_out;
  assign bus.res_seq       = seq_q;
  assign pass_cnt          = pass_q;
  assign fail_cnt          = fail_q;
  assign fifo_level        = level;
  assign busy              = busy_q;

`ifdef CA_CMP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo_cnt;

  // A handshake in the final wait cycle takes priority over the timeout
  assign tmo_hit = (state == WAIT_ACT) && !bus.act_valid && (tmo_cnt == TW'(TIMEOUT - 1));

  // Wait-cycle counter, held at zero outside WAIT_ACT
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_ACT) tmo_cnt <= '0;
    else if (!act_hs)             tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Timeout flag travels with the result
  always_ff @(posedge clk) begin
    if (rst)                    timed_out <= 1'b0;
    else if (tmo_hit)           timed_out <= 1'b1;
    else if (state == COMPARE)  timed_out <= 1'b0;
  end
`else
  assign tmo_hit   = 1'b0;
  assign timed_out = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (level != '0) state_next = WAIT_ACT;
      WAIT_ACT: begin
        if (act_hs)       state_next = COMPARE;
        else if (tmo_hit) state_next = REPORT;
      end
      COMPARE:  state_next = REPORT;
      REPORT:   if (res_hs) state_next = (level != '0) ? WAIT_ACT : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Field comparison of the captured pair
  always_comb begin
    mm_c = field_mismatch(exp_q, act_q);
    mc_c = '0;
    for (int i = 0; i < NUM_FIELDS; i++) mc_c = mc_c + MATCH_W'(!mm_c[i]);
  end

  // Capture the expected head and DUT packet on the act handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      act_q <= '0;
    end else if (act_hs) begin
      exp_q <= head;
      act_q <= bus.act_pkt;
    end
  end

  // Registered handshake flags, result fields and running totals
  always_ff @(posedge clk) begin
    if (rst) begin
      act_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mm_q        <= '0;
      mc_q        <= '0;
      seq_q       <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
    end else begin
      act_ready_q <= (state_next == WAIT_ACT);
      res_valid_q <= (state_next == REPORT);
      busy_q      <= (state_next != IDLE);
      if (state == COMPARE) begin
        mm_q <= mm_c;
        mc_q <= mc_c;
      end else if (tmo_hit) begin
        mm_q <= '1;
        mc_q <= '0;
      end
      if (res_hs) begin
        seq_q <= seq_q + SEQ_W'(1);
        if (mm_q == '0 && !timed_out) begin
          if (pass_q != '1) pass_q <= pass_q + TOT_W'(1);
        end else begin
          if (fail_q != '1) fail_q <= fail_q + TOT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ca_cmp_sequencer.sv
// Directed self-checking bench for ca_cmp_sequencer (DEPTH=4, TIMEOUT=8).
// The timeout scenario is included when CA_CMP_TIMEOUT_EN is defined.
module tb_ca_cmp_sequencer;
  import ca_cmp_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic [2:0]  fifo_level;
  logic        busy;
  int          n_checks = 0;
  int          n_fail   = 0;
  pkt_t        p [5];
  pkt_t        a;

  ca_cmp_sequencer_if bus ();

  ca_cmp_sequencer #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input pkt_t pk);
    bus.exp_valid = 1'b1;
    bus.exp_pkt   = pk;
    tick();
    bus.exp_valid = 1'b0;
  endtask

  // One expected packet, one DUT packet, result accepted immediately
  task automatic run_cmp(input string tag, input pkt_t e, input pkt_t act,
                         input logic [4:0] mm, input logic [2:0] mc, input logic [7:0] seq);
    push_exp(e);
    tick();
    check({tag, ".act_ready"}, 32'(bus.act_ready), 32'd1);
    bus.act_valid = 1'b1;
    bus.act_pkt   = act;
    tick();
    bus.act_valid = 1'b0;
    check({tag, ".valid_lat1"}, 32'(bus.res_valid), 32'd0);
    tick();
    check({tag, ".valid_lat2"}, 32'(bus.res_valid), 32'd1);
    check({tag, ".mismatch"}, 32'(bus.res_mismatch), 32'(mm));
    check({tag, ".match_cnt"}, 32'(bus.res_match_cnt), 32'(mc));
    check({tag, ".timeout"}, 32'(bus.res_timeout), 32'd0);
    check({tag, ".seq"}, 32'(bus.res_seq), 32'(seq));
    tick();
    check({tag, ".valid_clr"}, 32'(bus.res_valid), 32'd0);
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.exp_valid = 1'b0;
    bus.exp_pkt   = '0;
    bus.act_valid = 1'b0;
    bus.act_pkt   = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) p[i] = pkt_t'(28'h1234560 + 28'(i * 17));

    // Reset state
    repeat (3) tick();
    check("rst.exp_ready", 32'(bus.exp_ready), 32'd0);
    check("rst.act_ready", 32'(bus.act_ready), 32'd0);
    check("rst.res_valid", 32'(bus.res_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.level", 32'(fifo_level), 32'd0);
    check("rst.pass", 32'(pass_cnt), 32'd0);
    check("rst.fail", 32'(fail_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.exp_ready", 32'(bus.exp_ready), 32'd1);

    // Full match
    run_cmp("match", pkt_t'(28'h0ABCDEF), pkt_t'(28'h0ABCDEF), 5'b00000, 3'd5, 8'd0);
    check("match.pass", 32'(pass_cnt), 32'd1);
    check("match.fail", 32'(fail_cnt), 32'd0);
    check("match.seq_inc", 32'(bus.res_seq), 32'd1);

    // BCW only differs
    a      = pkt_t'(28'h0ABCDEF);
    a.bcw  = 6'h2A;
    begin
      pkt_t b;
      b     = a;
      b.bcw = 6'h15;
      run_cmp("bcw", a, b, 5'b01000, 3'd4, 8'd1);
    end
    check("bcw.fail", 32'(fail_cnt), 32'd1);
    check("bcw.pass", 32'(pass_cnt), 32'd1);

    // CA and DCA differ
    begin
      pkt_t b;
      b     = p[0];
      b.ca  = b.ca ^ 10'h200;
      b.dca = b.dca ^ 8'h01;
      run_cmp("ca_dca", p[0], b, 5'b10001, 3'd3, 8'd2);
    end
    check("ca_dca.fail", 32'(fail_cnt), 32'd2);

    // Fill the FIFO with no DUT packets
    for (int i = 0; i < 4; i++) begin
      bus.exp_valid = 1'b1;
      bus.exp_pkt   = p[i];
      tick();
    end
    bus.exp_valid = 1'b0;
    #1;
    check("full.level", 32'(fifo_level), 32'd4);
    check("full.exp_ready", 32'(bus.exp_ready), 32'd0);
    check("full.act_ready", 32'(bus.act_ready), 32'd1);
    // Act handshake on the head with a simultaneous 5th push
    bus.act_valid = 1'b1;
    bus.act_pkt   = p[0];
    bus.exp_valid = 1'b1;
    bus.exp_pkt   = p[4];
    #1;
    check("full_pop.exp_ready", 32'(bus.exp_ready), 32'd1);
    tick();
    bus.act_valid = 1'b0;
    bus.exp_valid = 1'b0;
    check("full_pop.level", 32'(fifo_level), 32'd4);
    check("full_pop.act_ready", 32'(bus.act_ready), 32'd0);
    tick();
    check("full_pop.valid", 32'(bus.res_valid), 32'd1);
    check("full_pop.mismatch", 32'(bus.res_mismatch), 32'd0);
    check("full_pop.match_cnt", 32'(bus.res_match_cnt), 32'd5);
    check("full_pop.seq", 32'(bus.res_seq), 32'd3);
    tick();
    check("full_pop.valid_clr", 32'(bus.res_valid), 32'd0);
    check("full_pop.pass", 32'(pass_cnt), 32'd2);
    check("full_pop.act_ready2", 32'(bus.act_ready), 32'd1);
    check("full_pop.seq2", 32'(bus.res_seq), 32'd4);

    // Result back-pressure for 10 cycles
    bus.res_ready = 1'b0;
    a             = p[1];
    a.cid         = a.cid ^ 3'h7;
    bus.act_valid = 1'b1;
    bus.act_pkt   = a;
    tick();
    bus.act_valid = 1'b0;
    check("hold.level", 32'(fifo_level), 32'd3);
    tick();
    for (int k = 0; k < 10; k++) begin
      check("hold.valid", 32'(bus.res_valid), 32'd1);
      check("hold.mismatch", 32'(bus.res_mismatch), 32'h04);
      check("hold.match_cnt", 32'(bus.res_match_cnt), 32'd4);
      check("hold.seq", 32'(bus.res_seq), 32'd4);
      check("hold.act_ready", 32'(bus.act_ready), 32'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    check("hold.valid_clr", 32'(bus.res_valid), 32'd0);
    check("hold.fail", 32'(fail_cnt), 32'd3);
    check("hold.seq_inc", 32'(bus.res_seq), 32'd5);
    check("hold.act_ready2", 32'(bus.act_ready), 32'd1);

    // Reset while in COMPARE with two packets queued
    bus.act_valid = 1'b1;
    bus.act_pkt   = p[2];
    tick();
    bus.act_valid = 1'b0;
    check("midrst.pre_level", 32'(fifo_level), 32'd2);
    check("midrst.pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst.level", 32'(fifo_level), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst.act_ready", 32'(bus.act_ready), 32'd0);
    check("midrst.exp_ready", 32'(bus.exp_ready), 32'd0);
    check("midrst.seq", 32'(bus.res_seq), 32'd0);
    check("midrst.mismatch", 32'(bus.res_mismatch), 32'd0);
    check("midrst.match_cnt", 32'(bus.res_match_cnt), 32'd0);
    check("midrst.pass", 32'(pass_cnt), 32'd0);
    check("midrst.fail", 32'(fail_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst.exp_ready_post", 32'(bus.exp_ready), 32'd1);
    repeat (3) tick();
    check("midrst.no_result", 32'(bus.res_valid), 32'd0);
    check("midrst.stay_idle", 32'(busy), 32'd0);

`ifdef CA_CMP_TIMEOUT_EN
    // Expected packet with no DUT packet times out 8 cycles after WAIT_ACT entry
    push_exp(p[3]);
    tick();
    check("tmo.act_ready", 32'(bus.act_ready), 32'd1);
    repeat (7) tick();
    check("tmo.early", 32'(bus.res_valid), 32'd0);
    tick();
    check("tmo.valid", 32'(bus.res_valid), 32'd1);
    check("tmo.flag", 32'(bus.res_timeout), 32'd1);
    check("tmo.mismatch", 32'(bus.res_mismatch), 32'h1F);
    check("tmo.match_cnt", 32'(bus.res_match_cnt), 32'd0);
    check("tmo.level", 32'(fifo_level), 32'd0);
    tick();
    check("tmo.fail", 32'(fail_cnt), 32'd1);
    check("tmo.pass", 32'(pass_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
